// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU bus sequencer: op codes, FSM encoding and watchdog limit.
// The watchdog itself is only built when ALU_IO_TIMEOUT_EN is defined.
package alu_io_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Only mul and div produce a meaningful Q half.
  function automatic logic op_has_lo(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/alu_io_capture.sv
// Result capture for the ALU bus sequencer: samples OUTBUS into the hi/lo result
// registers on push strobes; the lo half stays 0 for add/sub.
module alu_io_capture
  import alu_io_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_a_i,
  input  logic             push_q_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] outbus_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (clear_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (push_a_i) hi_q <= outbus_i;
      if (push_q_i && op_has_lo(op_i)) lo_q <= outbus_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/alu_io_sequencer.sv
// Bus-side front end for the ALU control unit: request handshake, BEGIN/op drive, INBUS
// operand muxing, OUTBUS capture and response handshake. Optional watchdog: ALU_IO_TIMEOUT_EN.
module alu_io_sequencer
  import alu_io_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_input,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_q,
  input  logic [WIDTH-1:0] req_m,
  output logic             cu_begin,
  output logic [1:0]       cu_op_code,
  input  logic             load_a,
  input  logic             load_q,
  input  logic             load_m,
  input  logic             push_a,
  input  logic             push_q,
  input  logic             cu_end,
  output logic [WIDTH-1:0] inbus,
  input  logic [WIDTH-1:0] outbus,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_err,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] reg_a_q, reg_q_q, reg_m_q;
  logic             accept;
  logic             active;
  logic             timeout;

  assign active = (state_q == ST_START) || (state_q == ST_RUN);
  assign accept = (state_q == ST_IDLE) && req_valid;

  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= req_op;
    end
  end

  // Operands are pure data; inbus is gated by the FSM, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      reg_a_q <= req_a;
      reg_q_q <= req_q;
      reg_m_q <= req_m;
    end
  end

`ifdef ALU_IO_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       err_q;

  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (active) wd_q <= wd_q + 8'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Fires on the last of TIMEOUT_CYCLES cycles in START+RUN unless END arrives then.
  assign timeout = active && !((state_q == ST_RUN) && cu_end) &&
                   (wd_q == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    cu_begin  = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_START;
      end
      ST_START: begin
        cu_begin = 1'b1;
        if (timeout) state_d = ST_RESP;
        else if (load_a || load_q || load_m) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cu_end || timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inbus = '0;
    if (active) begin
      if (load_a)      inbus = reg_a_q;
      else if (load_q) inbus = reg_q_q;
      else if (load_m) inbus = reg_m_q;
    end
  end

  alu_io_capture #(.WIDTH(WIDTH)) u_capture (
    .clk_i    (clk),
    .rst_i    (reset_input),
    .clear_i  (accept),
    .push_a_i (active && push_a),
    .push_q_i (active && push_q),
    .op_i     (op_q),
    .outbus_i (outbus),
    .hi_o     (rsp_hi),
    .lo_o     (rsp_lo)
  );

  assign cu_op_code = op_q;
  assign rsp_op     = op_q;
  assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_io_sequencer.sv
// Bench for alu_io_sequencer: table vectors, randomized transactions against an arithmetic
// reference, plus reset, backpressure and watchdog sequences.
module tb_alu_io_sequencer;
  import alu_io_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_input;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a, req_q, req_m;
  logic             cu_begin;
  logic [1:0]       cu_op_code;
  logic             load_a, load_q, load_m, push_a, push_q, cu_end;
  logic [WIDTH-1:0] inbus, outbus;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_op;
  logic [WIDTH-1:0] rsp_hi, rsp_lo;
  logic             rsp_err, busy;

  int checks = 0;
  int failures = 0;

  alu_io_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_input(reset_input),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_q(req_q), .req_m(req_m),
    .cu_begin(cu_begin), .cu_op_code(cu_op_code),
    .load_a(load_a), .load_q(load_q), .load_m(load_m),
    .push_a(push_a), .push_q(push_q), .cu_end(cu_end),
    .inbus(inbus), .outbus(outbus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, q, m;
    int         mode;     // 0: hi,lo,end  1: lo,hi,end  2: both,end  3: both with end
    int         hold;     // cycles of rsp_ready=0 in RESP
    int         wait_c;   // idle cycles in START before first load
    logic [7:0] push_hi, push_lo, exp_hi, exp_lo;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_load(input int which, input logic [7:0] exp, input string nm);
    load_a = (which == 0);
    load_q = (which == 1);
    load_m = (which == 2);
    #1 chk8(nm, inbus, exp);
    @(negedge clk);
    load_a = 1'b0; load_q = 1'b0; load_m = 1'b0;
  endtask

  task automatic cu_cycle(input logic pa, input logic pq, input logic en, input logic [7:0] ob);
    push_a = pa; push_q = pq; cu_end = en; outbus = ob;
    #1;
    chk8("inbus_no_load", inbus, 8'h00);
    chk1("rsp_valid_early", rsp_valid, 1'b0);
    @(negedge clk);
    push_a = 1'b0; push_q = 1'b0; cu_end = 1'b0; outbus = 8'($urandom);
  endtask

  task automatic txn(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_q = v.q; req_m = v.m;
    chk1("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_a = ~v.a; req_q = ~v.q; req_m = ~v.m;
    chk1("cu_begin_start", cu_begin, 1'b1);
    chk8("cu_op_code", 8'(cu_op_code), 8'(v.op));
    chk1("req_ready_busy", req_ready, 1'b0);
    repeat (v.wait_c) begin
      @(negedge clk);
      chk1("cu_begin_wait", cu_begin, 1'b1);
    end
    if (v.op != OP_MUL) do_load(0, v.a, "inbus_a");
    if (v.op[1])        do_load(1, v.q, "inbus_q");
    do_load(2, v.m, "inbus_m");
    chk1("cu_begin_run", cu_begin, 1'b0);
    case (v.mode)
      0: begin cu_cycle(1, 0, 0, v.push_hi); cu_cycle(0, 1, 0, v.push_lo); cu_cycle(0, 0, 1, 8'hEE); end
      1: begin cu_cycle(0, 1, 0, v.push_lo); cu_cycle(1, 0, 0, v.push_hi); cu_cycle(0, 0, 1, 8'hEE); end
      2: begin cu_cycle(1, 1, 0, v.push_hi); cu_cycle(0, 0, 1, 8'hEE); end
      default: cu_cycle(1, 1, 1, v.push_hi);
    endcase
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk8("rsp_hi", rsp_hi, v.exp_hi);
    chk8("rsp_lo", rsp_lo, v.exp_lo);
    chk8("rsp_op", 8'(rsp_op), 8'(v.op));
    chk1("rsp_err", rsp_err, 1'b0);
    repeat (v.hold) begin
      load_a = 1'b1; push_a = 1'b1; push_q = 1'b1; outbus = 8'h5A;
      #1 chk8("inbus_resp", inbus, 8'h00);
      @(negedge clk);
      chk1("rsp_valid_hold", rsp_valid, 1'b1);
      chk8("rsp_hi_hold", rsp_hi, v.exp_hi);
      chk8("rsp_lo_hold", rsp_lo, v.exp_lo);
      chk1("req_ready_hold", req_ready, 1'b0);
    end
    load_a = 1'b0; push_a = 1'b0; push_q = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1("rsp_valid_done", rsp_valid, 1'b0);
    chk1("req_ready_done", req_ready, 1'b1);
    chk1("busy_done", busy, 1'b0);
  endtask

  // Reference: the CU model pushes the true arithmetic result; the lo half is
  // zero for add/sub and equals the shared bus value when both pushes coincide.
  function automatic vec_t gen_random();
    vec_t v;
    logic [15:0] p;
    v.op = 2'($urandom_range(0, 3));
    v.a = 8'($urandom); v.q = 8'($urandom); v.m = 8'($urandom);
    v.mode = int'($urandom_range(0, 3));
    v.hold = int'($urandom_range(0, 3));
    v.wait_c = int'($urandom_range(0, 2));
    v.push_lo = 8'($urandom);
    case (v.op)
      OP_ADD: v.push_hi = 8'(v.a + v.m);
      OP_SUB: v.push_hi = 8'(v.a - v.m);
      OP_MUL: begin
        p = 16'(v.q) * 16'(v.m);
        v.push_hi = p[15:8];
        v.push_lo = p[7:0];
      end
      default: begin
        v.m = 8'($urandom_range(1, 255));
        v.a = 8'($urandom % 32'(v.m));
        p = {v.a, v.q};
        v.push_lo = 8'(p / 16'(v.m));
        v.push_hi = 8'(p % 16'(v.m));
      end
    endcase
    v.exp_hi = v.push_hi;
    if (v.op == OP_ADD || v.op == OP_SUB) v.exp_lo = 8'h00;
    else v.exp_lo = (v.mode >= 2) ? v.push_hi : v.push_lo;
    return v;
  endfunction

  initial begin
    vec_t tbl[5];
    int n;
    tbl[0] = '{op:OP_ADD, a:8'h05, q:8'h00, m:8'h03, mode:0, hold:0, wait_c:0,
               push_hi:8'h08, push_lo:8'h77, exp_hi:8'h08, exp_lo:8'h00};
    tbl[1] = '{op:OP_MUL, a:8'h00, q:8'h12, m:8'h34, mode:0, hold:1, wait_c:1,
               push_hi:8'h03, push_lo:8'hA8, exp_hi:8'h03, exp_lo:8'hA8};
    tbl[2] = '{op:OP_DIV, a:8'h00, q:8'h64, m:8'h07, mode:1, hold:0, wait_c:0,
               push_hi:8'h02, push_lo:8'h0E, exp_hi:8'h02, exp_lo:8'h0E};
    tbl[3] = '{op:OP_SUB, a:8'h10, q:8'h44, m:8'h03, mode:3, hold:10, wait_c:0,
               push_hi:8'h0D, push_lo:8'h99, exp_hi:8'h0D, exp_lo:8'h00};
    tbl[4] = '{op:OP_MUL, a:8'h21, q:8'h0F, m:8'h0F, mode:2, hold:0, wait_c:2,
               push_hi:8'hC3, push_lo:8'h00, exp_hi:8'hC3, exp_lo:8'hC3};

    reset_input = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_q = '0; req_m = '0;
    load_a = 1'b0; load_q = 1'b0; load_m = 1'b0;
    push_a = 1'b0; push_q = 1'b0; cu_end = 1'b0;
    outbus = '0; rsp_ready = 1'b0;
    #1 reset_input = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_cu_begin", cu_begin, 1'b0);
    chk8("rst_cu_op_code", 8'(cu_op_code), 8'h00);
    chk8("rst_inbus", inbus, 8'h00);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk8("rst_rsp_hi", rsp_hi, 8'h00);
    chk8("rst_rsp_lo", rsp_lo, 8'h00);
    chk8("rst_rsp_op", 8'(rsp_op), 8'h00);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset_input = 1'b0;

    for (int i = 0; i < 5; i++) txn(tbl[i]);
    for (int i = 0; i < 40; i++) txn(gen_random());

    // Reset mid-RUN with loads still asserted.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 8'h11; req_q = 8'h22; req_m = 8'h33;
    @(negedge clk);
    req_valid = 1'b0;
    do_load(0, 8'h11, "inbus_a_prerst");
    load_q = 1'b1; load_m = 1'b1;
    #1 chk8("inbus_prio_qm", inbus, 8'h22);
    load_a = 1'b1;
    #1 chk8("inbus_prio_a", inbus, 8'h11);
    @(negedge clk);
    load_q = 1'b0; load_m = 1'b0;
    push_a = 1'b1; outbus = 8'h55;
    @(negedge clk);
    push_a = 1'b0;
    chk8("hi_before_rst", rsp_hi, 8'h55);
    #2 reset_input = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_req_ready", req_ready, 1'b1);
    chk8("arst_inbus", inbus, 8'h00);
    chk8("arst_rsp_hi", rsp_hi, 8'h00);
    chk8("arst_cu_op_code", 8'(cu_op_code), 8'h00);
    @(negedge clk);
    reset_input = 1'b0; load_a = 1'b0; cu_end = 1'b1;
    @(negedge clk);
    cu_end = 1'b0;
    chk1("postrst_rsp_valid", rsp_valid, 1'b0);
    chk1("postrst_busy", busy, 1'b0);
    chk1("postrst_req_ready", req_ready, 1'b1);

    // Control unit that never signals END.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 8'h01; req_m = 8'h02;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 400 && busy && !rsp_valid; k++) begin
      load_a = (k == 0); push_a = (k == 1); outbus = 8'h9C;
      n++;
      @(negedge clk);
    end
    load_a = 1'b0; push_a = 1'b0;
`ifdef ALU_IO_TIMEOUT_EN
    chkn("wd_cycles", n, TIMEOUT_CYCLES);
    chk1("wd_rsp_valid", rsp_valid, 1'b1);
    chk1("wd_rsp_err", rsp_err, 1'b1);
    chk1("wd_cu_begin", cu_begin, 1'b0);
    chk8("wd_rsp_hi", rsp_hi, 8'h9C);
`else
    chkn("nowd_cycles", n, 400);
    chk1("nowd_busy", busy, 1'b1);
    chk1("nowd_rsp_err", rsp_err, 1'b0);
    chk1("nowd_rsp_valid", rsp_valid, 1'b0);
    cu_end = 1'b1;
    @(negedge clk);
    cu_end = 1'b0;
    chk1("nowd_end_valid", rsp_valid, 1'b1);
    chk8("nowd_rsp_hi", rsp_hi, 8'h9C);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1("final_idle", req_ready, 1'b1);
    chk1("final_err_clear_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
